elevator_request_capture: RTL

Parametrised capture of elevator car-panel requests. Decodes a one-hot push-button vector into 1-based floor numbers and pairs two successive distinct presses into a (current, destination) request. Completed pairs are queued in a DEPTH-entry FIFO and presented to the motion controller over a valid/ready handshake. Handles incomplete-pair timeout, same-floor rejection and queue overflow.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/elevator_request_capture_if.sv | 31 +++
 rtl/elevator_req_fifo.sv | 49 ++++
 rtl/elevator_request_capture.sv | 118 +++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator request capture block.
package elevator_pkg;

   localparam int unsigned NO_FLOOR    = 0;
   localparam int unsigned MAX_FLOOR_W = 8;

   typedef logic [MAX_FLOOR_W-1:0] floor_t;

   typedef struct packed {
      floor_t current;
      floor_t dest;
   } req_t;

   typedef enum logic [0:0] {StIdle, StWaitDest} state_e;

   function automatic int unsigned floor_w(int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/elevator_request_capture_if.sv
// Car-panel buttons in, request handshake and status pulses out.
interface elevator_request_capture_if
   import elevator_pkg::*;
#(
   parameter int unsigned N_FLOORS = 9,
   parameter int unsigned FLOOR_W  = floor_w(N_FLOORS),
   parameter int unsigned CNT_W    = 3
);
   logic [N_FLOORS-1:0] push_btns;
   logic                req_valid;
   logic                req_ready;
   logic [FLOOR_W-1:0]  req_current;
   logic [FLOOR_W-1:0]  req_dest;
   logic                pair_pending;
   logic [CNT_W-1:0]    fifo_count;
   logic                overflow;
   logic                pair_err;
   logic                timeout;

   modport master (
      input  push_btns, req_ready,
      output req_valid, req_current, req_dest, pair_pending, fifo_count,
             overflow, pair_err, timeout
   );

   modport slave (
      output push_btns, req_ready,
      input  req_valid, req_current, req_dest, pair_pending, fifo_count,
             overflow, pair_err, timeout
   );
endinterface

// File: rtl/elevator_req_fifo.sv
// First-word-fall-through request FIFO; head data reads as zero when empty.
module elevator_req_fifo
   import elevator_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  req_t             i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output req_t             o_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_push_ok
);
   req_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;
   logic             w_full;

   assign o_valid   = (r_count != '0);
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_pop     = i_pop && o_valid;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign o_push_ok = i_push && (!w_full || w_pop);
   assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count   = r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (o_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(o_push_ok) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (o_push_ok) r_mem[r_wr_ptr] <= i_data;
   end
endmodule

// File: rtl/elevator_request_capture.sv
// Pairs two distinct car-panel presses into (current, dest) requests and queues them.
module elevator_request_capture
   import elevator_pkg::*;
#(
   parameter int unsigned N_FLOORS     = 9,
   parameter int unsigned FLOOR_W      = floor_w(N_FLOORS),
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned PAIR_TIMEOUT = 1000
) (
   input logic                        i_clk,
   input logic                        i_rst,
   elevator_request_capture_if.master io_bus
);
   localparam int unsigned TMR_W = (PAIR_TIMEOUT > 0) ? $clog2(PAIR_TIMEOUT + 1) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_e             r_state;
   logic [FLOOR_W-1:0] r_prev_floor;
   logic [FLOOR_W-1:0] r_cur_floor;
   logic [TMR_W-1:0]   r_timer;
   logic               r_overflow;
   logic               r_pair_err;
   logic               r_timeout;
   logic [FLOOR_W-1:0] w_decoded;
   int unsigned        w_hot_cnt;
   logic               w_event;
   logic               w_push;
   logic               w_push_ok;
   logic               w_valid;
   req_t               w_push_data;
   req_t               w_head;
   logic [CNT_W-1:0]   w_count;

   always_comb begin
      w_decoded = FLOOR_W'(NO_FLOOR);
      w_hot_cnt = 0;
      for (int i = 0; i < int'(N_FLOORS); i++) begin
         if (io_bus.push_btns[i]) begin
            w_decoded = FLOOR_W'(i + 1);
            w_hot_cnt = w_hot_cnt + 1;
         end
      end
      if (w_hot_cnt != 1) w_decoded = FLOOR_W'(NO_FLOOR);
   end

   assign w_event     = (w_decoded != FLOOR_W'(NO_FLOOR)) && (w_decoded != r_prev_floor);
   assign w_push      = (r_state == StWaitDest) && w_event && (w_decoded != r_cur_floor);
   assign w_push_data = '{current: floor_t'(r_cur_floor), dest: floor_t'(w_decoded)};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_prev_floor <= '0;
         r_cur_floor  <= '0;
         r_timer      <= '0;
         r_overflow   <= 1'b0;
         r_pair_err   <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_prev_floor <= w_decoded;
         r_overflow   <= 1'b0;
         r_pair_err   <= 1'b0;
         r_timeout    <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_event) begin
                  r_cur_floor <= w_decoded;
                  r_timer     <= '0;
                  r_state     <= StWaitDest;
               end
            end
            StWaitDest: begin
               // A press beats a timer expiry landing on the same edge.
               if (w_event) begin
                  r_state <= StIdle;
                  if (w_decoded == r_cur_floor) r_pair_err <= 1'b1;
                  else if (!w_push_ok)          r_overflow <= 1'b1;
               end else if (PAIR_TIMEOUT != 0 && r_timer == TMR_W'(PAIR_TIMEOUT)) begin
                  r_timeout <= 1'b1;
                  r_state   <= StIdle;
               end else if (r_timer != TMR_W'(PAIR_TIMEOUT)) begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   elevator_req_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_push   (w_push),
      .i_data   (w_push_data),
      .i_pop    (io_bus.req_ready),
      .o_valid  (w_valid),
      .o_data   (w_head),
      .o_count  (w_count),
      .o_push_ok(w_push_ok)
   );

   if (FLOOR_W < MAX_FLOOR_W) begin : g_hi_bits
      logic w_unused_hi;
      assign w_unused_hi = ^{w_head.current[MAX_FLOOR_W-1:FLOOR_W],
                             w_head.dest[MAX_FLOOR_W-1:FLOOR_W]};
   end

   assign io_bus.req_valid    = w_valid;
   assign io_bus.req_current  = w_head.current[FLOOR_W-1:0];
   assign io_bus.req_dest     = w_head.dest[FLOOR_W-1:0];
   assign io_bus.fifo_count   = w_count;
   assign io_bus.pair_pending = (r_state == StWaitDest);
   assign io_bus.overflow     = r_overflow;
   assign io_bus.pair_err     = r_pair_err;
   assign io_bus.timeout      = r_timeout;
endmodule
